lcd_reader: RTL and testbench
=============================

# lcd_reader

Read-side companion to the HD44780 write controller: performs single LCD read cycles (busy flag + address counter with RS=0, DDRAM/CGRAM data with RS=1) and returns the byte to the requester. It sits between a command sequencer and the LCD pins, sharing LCD_RW/LCD_EN/LCD_RS with the write controller through the top-level mux. Optionally it autonomously polls the busy flag until the display is ready, so sequencers can replace fixed delay counters with a ready wait.

## Interface
- SETUP_CYC, 4, clocks RS/RW stable before EN rises (tAS; 80 ns at 50 MHz)
- EN_HIGH_CYC, 16, clocks EN held high (≥ tPW + tDDR)
- HOLD_CYC, 4, clocks RS/RW held after EN falls
- POLL_GAP_CYC, 8, idle clocks between successive poll reads
- POLL_MAX, 4096, maximum poll reads before timeout
- clk  input  1  system clock
- rst  input  1  reset; asynchronous and active-low
- rd_start  input  1  request one read (sampled in IDLE only)
- rd_rs  input  1  register select for the read, latched with rd_start
- poll_start  input  1  request busy-flag poll (active only with LCD_READ_POLL_EN)
- lcd_data_in  input  8  LCD data bus as seen through the top-level tristate
- rd_data  output  8  captured byte, valid while rd_done=1 and held until the next capture
- rd_done  output  1  one-cycle completion pulse
- rd_busy  output  1  high whenever state ≠ IDLE
- poll_timeout  output  1  qualifies rd_done: poll ended without BF=0
- lcd_bus_rel  output  1  top level must tristate LCD_DATA
- LCD_RW, LCD_EN, LCD_RS  output  1 each  LCD control pins

## Operation
- States: IDLE, SETUP, ENABLE, HOLD, DONE, GAP (GAP only with the macro).
- IDLE: all outputs low except rd_data (held). rd_start=1 latches rd_rs, goes to SETUP.
- SETUP: LCD_RW=1, LCD_RS=latched rs, lcd_bus_rel=1, for SETUP_CYC cycles, then ENABLE.
- ENABLE: additionally LCD_EN=1 for EN_HIGH_CYC cycles; lcd_data_in captured into rd_data on the clock edge that ends the last ENABLE cycle; then HOLD.
- HOLD: LCD_EN=0, RW/RS/bus_rel held for HOLD_CYC cycles; then DONE (single read) or poll decision.
- DONE: rd_done=1 for exactly one cycle, RW/RS/bus_rel still held; next state IDLE, where all return to 0.
- Requests arriving outside IDLE are ignored (not queued); requester waits for rd_busy=0.
- Counter widths sized by $clog2 of the largest parameter; each phase counts exactly its parameter value (parameter 0 not supported, minimum 1).

## Timing
- Reset (async, any state): state=IDLE, LCD_EN=LCD_RW=LCD_RS=0, lcd_bus_rel=0, rd_done=0, rd_busy=0, poll_timeout=0, rd_data=0. EN drops in the same instant as rst falls; an interrupted read produces no rd_done.
- rd_start sampled high at edge k → LCD_RW=1 from cycle k+1; LCD_EN high cycles k+1+SETUP_CYC … k+SETUP_CYC+EN_HIGH_CYC; rd_done at cycle k+SETUP_CYC+EN_HIGH_CYC+HOLD_CYC+1 (k+25 with defaults).
- Back-to-back: earliest next accepted rd_start is the IDLE cycle after DONE.
- rd_start and poll_start high together: poll wins (with macro); rd_start wins (without).

## Configuration
- LCD_READ_POLL_EN defined: poll_start in IDLE starts reads with RS forced 0. After each HOLD: rd_data[7]=0 → DONE with poll_timeout=0; else if reads done = POLL_MAX → DONE with poll_timeout=1; else GAP for POLL_GAP_CYC cycles (RW=1, EN=0, bus_rel=1) then SETUP. poll_timeout is valid only alongside rd_done and cleared on entering IDLE.
- Not defined: poll_start ignored, GAP state and poll counter absent, poll_timeout tied 0.

## Structure
- Package lcd_pkg: state enum, default timing constants, LCD_BF_BIT=7, RS_INSTR=0/RS_DATA=1; shared with the write controller.
- One sub-module: lcd_phase_timer (loadable down-counter, load/zero flag), instanced once for all phases.

## Test plan
- Single read rd_rs=1, lcd_data_in=8'h41 → EN high exactly 16 cycles, rd_done at k+25, rd_data=8'h41, LCD_RS=1 throughout.
- Read rd_rs=0, bus changes 8'h00→8'h8C mid-ENABLE → rd_data=8'h8C (captured at EN end), LCD_RS=0.
- rd_start pulsed during ENABLE → ignored, exactly one rd_done.
- rst low during ENABLE → LCD_EN=0 immediately, no rd_done, all outputs reset values; new read afterwards completes normally.
- Macro on, BF=1 for 3 reads then 8'h05 → 4 EN pulses separated by GAP, rd_done with rd_data=8'h05, poll_timeout=0.
- Macro on, POLL_MAX=4, BF stuck at 1 → 4 EN pulses, rd_done with poll_timeout=1; macro off, poll_start → no activity.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared LCD definitions for the HD44780 read/write controllers.
// The GAP state exists only when LCD_READ_POLL_EN is defined.
package lcd_pkg;

  localparam int LCD_SETUP_CYC    = 4;
  localparam int LCD_EN_HIGH_CYC  = 16;
  localparam int LCD_HOLD_CYC     = 4;
  localparam int LCD_POLL_GAP_CYC = 8;
  localparam int LCD_POLL_MAX     = 4096;

  localparam int   LCD_BF_BIT = 7;
  localparam logic RS_INSTR   = 1'b0;
  localparam logic RS_DATA    = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ENABLE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
`ifdef LCD_READ_POLL_EN
    , ST_GAP  = 3'd5
`endif
  } lcd_rd_state_e;

  function automatic int lcd_max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Timers are loaded with N-1, so clog2(N) bits hold the largest phase.
  function automatic int lcd_cnt_width(input int max_val);
    return (max_val <= 2) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter shared by every phase of the LCD read sequencer.
// zero is high once the count has run out; load takes priority over counting.
module lcd_phase_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/lcd_reader.sv
// Single-cycle HD44780 read sequencer (busy flag/address or RAM data).
// Define LCD_READ_POLL_EN to add autonomous busy-flag polling via poll_start.
module lcd_reader
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC    = LCD_SETUP_CYC,
  parameter int EN_HIGH_CYC  = LCD_EN_HIGH_CYC,
  parameter int HOLD_CYC     = LCD_HOLD_CYC,
  parameter int POLL_GAP_CYC = LCD_POLL_GAP_CYC,
  parameter int POLL_MAX     = LCD_POLL_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rd_start,
  input  logic       rd_rs,
  input  logic       poll_start,
  input  logic [7:0] lcd_data_in,
  output logic [7:0] rd_data,
  output logic       rd_done,
  output logic       rd_busy,
  output logic       poll_timeout,
  output logic       lcd_bus_rel,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_RS
);

  localparam int MAX_CYC = lcd_max4(SETUP_CYC, EN_HIGH_CYC, HOLD_CYC, POLL_GAP_CYC);
  localparam int TW      = lcd_cnt_width(MAX_CYC);

  localparam logic [TW-1:0] SETUP_LD = TW'(SETUP_CYC - 1);
  localparam logic [TW-1:0] EN_LD    = TW'(EN_HIGH_CYC - 1);
  localparam logic [TW-1:0] HOLD_LD  = TW'(HOLD_CYC - 1);

  if (SETUP_CYC < 1 || EN_HIGH_CYC < 1 || HOLD_CYC < 1 || POLL_GAP_CYC < 1 || POLL_MAX < 1)
  begin : g_bad_timing
    $error("lcd_reader: every timing parameter must be at least 1");
  end

  lcd_rd_state_e   state_q, state_d;
  logic            rs_q, rs_d;
  logic [7:0]      rd_data_q, rd_data_d;
  logic            rd_done_q, rd_done_d;
  logic            rd_busy_q, rd_busy_d;
  logic            lcd_rw_q, lcd_rw_d;
  logic            lcd_en_q, lcd_en_d;
  logic            lcd_rs_q, lcd_rs_d;
  logic            bus_rel_q, bus_rel_d;
  logic            tmr_load;
  logic [TW-1:0]   tmr_val;
  logic            tmr_zero;

`ifdef LCD_READ_POLL_EN
  localparam int             PW     = $clog2(POLL_MAX + 1);
  localparam logic [TW-1:0]  GAP_LD = TW'(POLL_GAP_CYC - 1);

  logic            polling_q, polling_d;
  logic [PW-1:0]   poll_cnt_q, poll_cnt_d;
  logic            timeout_q, timeout_d;
`else
  logic unused_poll_start;
  assign unused_poll_start = poll_start;
`endif

  lcd_phase_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Next-state logic; the pin outputs are decoded from the next state so
  // they change on the same edge as the state register.
  always_comb begin
    state_d   = state_q;
    rs_d      = rs_q;
    rd_data_d = rd_data_q;
`ifdef LCD_READ_POLL_EN
    polling_d  = polling_q;
    poll_cnt_d = poll_cnt_q;
    timeout_d  = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
`ifdef LCD_READ_POLL_EN
        if (poll_start) begin
          state_d    = ST_SETUP;
          rs_d       = RS_INSTR;
          polling_d  = 1'b1;
          poll_cnt_d = '0;
        end else if (rd_start) begin
          state_d   = ST_SETUP;
          rs_d      = rd_rs;
          polling_d = 1'b0;
        end
`else
        if (rd_start) begin
          state_d = ST_SETUP;
          rs_d    = rd_rs;
        end
`endif
      end
      ST_SETUP: begin
        if (tmr_zero) state_d = ST_ENABLE;
      end
      ST_ENABLE: begin
        if (tmr_zero) begin
          state_d   = ST_HOLD;
          rd_data_d = lcd_data_in;
`ifdef LCD_READ_POLL_EN
          if (polling_q) poll_cnt_d = poll_cnt_q + PW'(1);
`endif
        end
      end
      ST_HOLD: begin
        if (tmr_zero) begin
`ifdef LCD_READ_POLL_EN
          if (!polling_q || !rd_data_q[LCD_BF_BIT]) begin
            state_d = ST_DONE;
          end else if (poll_cnt_q == PW'(POLL_MAX)) begin
            state_d   = ST_DONE;
            timeout_d = 1'b1;
          end else begin
            state_d = ST_GAP;
          end
`else
          state_d = ST_DONE;
`endif
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
`ifdef LCD_READ_POLL_EN
      ST_GAP: begin
        if (tmr_zero) state_d = ST_SETUP;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    rd_busy_d = (state_d != ST_IDLE);
    lcd_rw_d  = rd_busy_d;
    bus_rel_d = rd_busy_d;
    lcd_rs_d  = rd_busy_d & rs_d;
    lcd_en_d  = (state_d == ST_ENABLE);
    rd_done_d = (state_d == ST_DONE);
  end

  // Each phase is timed by reloading the shared counter on every state change.
  always_comb begin
    tmr_load = (state_d != state_q);
    tmr_val  = '0;
    case (state_d)
      ST_SETUP:  tmr_val = SETUP_LD;
      ST_ENABLE: tmr_val = EN_LD;
      ST_HOLD:   tmr_val = HOLD_LD;
`ifdef LCD_READ_POLL_EN
      ST_GAP:    tmr_val = GAP_LD;
`endif
      default:   tmr_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      rs_q       <= RS_INSTR;
      rd_data_q  <= '0;
      rd_done_q  <= 1'b0;
      rd_busy_q  <= 1'b0;
      lcd_rw_q   <= 1'b0;
      lcd_en_q   <= 1'b0;
      lcd_rs_q   <= 1'b0;
      bus_rel_q  <= 1'b0;
`ifdef LCD_READ_POLL_EN
      polling_q  <= 1'b0;
      poll_cnt_q <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rs_q       <= rs_d;
      rd_data_q  <= rd_data_d;
      rd_done_q  <= rd_done_d;
      rd_busy_q  <= rd_busy_d;
      lcd_rw_q   <= lcd_rw_d;
      lcd_en_q   <= lcd_en_d;
      lcd_rs_q   <= lcd_rs_d;
      bus_rel_q  <= bus_rel_d;
`ifdef LCD_READ_POLL_EN
      polling_q  <= polling_d;
      poll_cnt_q <= poll_cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign rd_data     = rd_data_q;
  assign rd_done     = rd_done_q;
  assign rd_busy     = rd_busy_q;
  assign lcd_bus_rel = bus_rel_q;
  assign LCD_RW      = lcd_rw_q;
  assign LCD_EN      = lcd_en_q;
  assign LCD_RS      = lcd_rs_q;
`ifdef LCD_READ_POLL_EN
  assign poll_timeout = timeout_q;
`else
  assign poll_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_reader.sv
// Self-checking bench for lcd_reader: table-driven and random reads against
// a cycle-offset model; polling cases run when LCD_READ_POLL_EN is defined.
`timescale 1ns/1ps
module tb_lcd_reader;

  localparam int S      = 4;
  localparam int E      = 16;
  localparam int H      = 4;
  localparam int G      = 8;
  localparam int PMAX   = 4;
  localparam int RD_LEN = S + E + H;
  localparam int PERIOD = RD_LEN + G;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rd_start = 1'b0;
  logic       rd_rs = 1'b0;
  logic       poll_start = 1'b0;
  logic [7:0] lcd_data_in = 8'h00;
  logic [7:0] rd_data;
  logic       rd_done, rd_busy, poll_timeout, lcd_bus_rel, LCD_RW, LCD_EN, LCD_RS;

  always #5 clk = ~clk;

  lcd_reader #(
    .SETUP_CYC    (S),
    .EN_HIGH_CYC  (E),
    .HOLD_CYC     (H),
    .POLL_GAP_CYC (G),
    .POLL_MAX     (PMAX)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rd_start     (rd_start),
    .rd_rs        (rd_rs),
    .poll_start   (poll_start),
    .lcd_data_in  (lcd_data_in),
    .rd_data      (rd_data),
    .rd_done      (rd_done),
    .rd_busy      (rd_busy),
    .poll_timeout (poll_timeout),
    .lcd_bus_rel  (lcd_bus_rel),
    .LCD_RW       (LCD_RW),
    .LCD_EN       (LCD_EN),
    .LCD_RS       (LCD_RS)
  );

  typedef struct {
    logic       rs;
    logic [7:0] v0;
    logic [7:0] v1;
    int         sw;
    int         glitch;
    logic [7:0] exp_data;
  } vec_t;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] bus_tbl [0:255];
  logic [7:0] poll_vals [0:7];
  vec_t       vecs [5];

  function automatic logic [6:0] ctrl_vec();
    return {LCD_RW, LCD_EN, LCD_RS, lcd_bus_rel, rd_busy, rd_done, poll_timeout};
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, required);
    end
  endtask

  task automatic fill_bus(input logic [7:0] v0, input logic [7:0] v1, input int sw);
    for (int i = 0; i < 256; i++) bus_tbl[i] = (i < sw) ? v0 : v1;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 256; i++) bus_tbl[i] = 8'($urandom);
  endtask

  // Busy flag reads: bus value for read i is presented through its whole slot.
  task automatic fill_poll();
    for (int i = 0; i < 256; i++) bus_tbl[i] = poll_vals[i / PERIOD];
  endtask

  task automatic poll_model(output int n, output logic [7:0] d, output bit to);
    n  = PMAX;
    d  = poll_vals[PMAX-1];
    to = 1'b1;
    for (int i = PMAX - 1; i >= 0; i--) begin
      if (!poll_vals[i][7]) begin
        n  = i + 1;
        d  = poll_vals[i];
        to = 1'b0;
      end
    end
  endtask

  // Issues one request and follows it sample by sample; s=0 is #1 after the
  // accepting edge. Pulse p occupies [p*PERIOD+S, p*PERIOD+S+E-1].
  task automatic apply_stimulus(input string name, input bit req_rd, input bit req_poll,
                                input bit rs, input bit exp_rs, input int exp_pulses,
                                input logic [7:0] exp_data, input bit exp_to, input int glitch_s);
    int         done_s;
    int         en_seen;
    int         done_at;
    int         wave_err;
    int         first_err;
    logic [6:0] exp_v, got_v, err_got, err_exp;
    done_s    = (exp_pulses - 1) * PERIOD + RD_LEN;
    en_seen   = 0;
    done_at   = -1;
    wave_err  = 0;
    first_err = -1;
    err_got   = '0;
    err_exp   = '0;
    rd_rs       = rs;
    rd_start    = req_rd;
    poll_start  = req_poll;
    lcd_data_in = bus_tbl[0];
    @(posedge clk); #1;
    rd_start   = 1'b0;
    poll_start = 1'b0;
    for (int s = 0; s <= done_s + 1; s++) begin
      if (s <= done_s)
        exp_v = {1'b1, (s < done_s) && ((s % PERIOD) >= S) && ((s % PERIOD) < S + E),
                 exp_rs, 1'b1, 1'b1, s == done_s, (s == done_s) && exp_to};
      else
        exp_v = '0;
      got_v = ctrl_vec();
      if (LCD_EN) en_seen++;
      if (rd_done && done_at < 0) done_at = s;
      if (got_v !== exp_v) begin
        wave_err++;
        if (first_err < 0) begin
          first_err = s;
          err_got   = got_v;
          err_exp   = exp_v;
        end
      end
      if (s == done_s)     check_output({name, ":rd_data"}, 32'(rd_data), 32'(exp_data));
      if (s == done_s + 1) check_output({name, ":rd_data_hold"}, 32'(rd_data), 32'(exp_data));
      if (s <= done_s) begin
        lcd_data_in = bus_tbl[s];
        rd_start    = (s == glitch_s);
        poll_start  = (s == glitch_s);
        @(posedge clk); #1;
      end
    end
    rd_start   = 1'b0;
    poll_start = 1'b0;
    check_output({name, ":done_time"}, 32'(done_at), 32'(done_s));
    check_output({name, ":en_cycles"}, 32'(en_seen), 32'(exp_pulses * E));
    checks++;
    if (wave_err != 0) begin
      failures++;
      $display("[TB] FAIL %s:waveform %0d bad cycles, first s=%0d got %b want %b (rw,en,rs,rel,busy,done,to)",
               name, wave_err, first_err, err_got, err_exp);
    end
  endtask

  task automatic watch_idle(input string name, input int ncyc);
    int act;
    act = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk); #1;
      if (rd_busy || rd_done || LCD_EN || LCD_RW) act++;
    end
    check_output(name, 32'(act), 32'd0);
  endtask

  initial begin
    int         n;
    logic [7:0] d;
    bit         to;
    bit         rs;

    vecs[0] = '{1'b1, 8'h41, 8'h41, 0,         -1,     8'h41};
    vecs[1] = '{1'b0, 8'h00, 8'h8C, S + 8,     -1,     8'h8C};
    vecs[2] = '{1'b1, 8'h5A, 8'hA5, S + E - 1, 10,     8'hA5};
    vecs[3] = '{1'b0, 8'h3C, 8'hC3, S + E,     RD_LEN, 8'h3C};
    vecs[4] = '{1'b1, 8'hFF, 8'h00, S + E - 1, 0,      8'h00};

    repeat (3) @(posedge clk);
    #1;
    check_output("reset_ctrl", 32'(ctrl_vec()), 32'd0);
    check_output("reset_rd_data", 32'(rd_data), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      fill_bus(vecs[i].v0, vecs[i].v1, vecs[i].sw);
      apply_stimulus($sformatf("vec%0d", i), 1'b1, 1'b0, vecs[i].rs, vecs[i].rs, 1,
                     vecs[i].exp_data, 1'b0, vecs[i].glitch);
    end

    for (int i = 0; i < 8; i++) begin
      rs = 1'($urandom_range(0, 1));
      fill_random();
      apply_stimulus($sformatf("rand%0d", i), 1'b1, 1'b0, rs, rs, 1,
                     bus_tbl[S + E - 1], 1'b0, int'($urandom_range(0, RD_LEN)));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    fill_bus(8'h77, 8'h77, 0);
    lcd_data_in = 8'h77;
    rd_rs       = 1'b1;
    rd_start    = 1'b1;
    @(posedge clk); #1;
    rd_start = 1'b0;
    repeat (S + 5) @(posedge clk);
    #3;
    check_output("pre_reset_en", 32'(LCD_EN), 32'd1);
    rst = 1'b0;
    #1;
    check_output("reset_async_ctrl", 32'(ctrl_vec()), 32'd0);
    check_output("reset_async_data", 32'(rd_data), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    watch_idle("no_done_after_reset", 40);
    fill_random();
    apply_stimulus("after_reset", 1'b1, 1'b0, 1'b1, 1'b1, 1, bus_tbl[S + E - 1], 1'b0, -1);

`ifdef LCD_READ_POLL_EN
    poll_vals = '{8'h80, 8'hFF, 8'hC0, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    fill_poll();
    poll_model(n, d, to);
    apply_stimulus("poll_bf3", 1'b0, 1'b1, 1'b1, 1'b0, n, d, to, 30);

    poll_vals = '{8'h80, 8'h9F, 8'hC0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
    fill_poll();
    poll_model(n, d, to);
    apply_stimulus("poll_timeout", 1'b0, 1'b1, 1'b0, 1'b0, n, d, to, -1);

    poll_vals = '{8'h07, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    fill_poll();
    poll_model(n, d, to);
    apply_stimulus("both_poll_wins", 1'b1, 1'b1, 1'b1, 1'b0, n, d, to, -1);

    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 8; j++) begin
        poll_vals[j] = 8'($urandom);
        poll_vals[j][7] = ($urandom_range(0, 9) < 7);
      end
      fill_poll();
      poll_model(n, d, to);
      apply_stimulus($sformatf("poll_rand%0d", i), 1'b0, 1'b1, 1'b1, 1'b0, n, d, to, -1);
    end
`else
    rd_rs      = 1'b1;
    poll_start = 1'b1;
    @(posedge clk); #1;
    poll_start = 1'b0;
    watch_idle("poll_ignored", 30);

    fill_random();
    apply_stimulus("both_rd_wins", 1'b1, 1'b1, 1'b1, 1'b1, 1, bus_tbl[S + E - 1], 1'b0, -1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
